// File: rtl/mem_arbiter_if.sv
// Bundle of all cache-side and memory-side signals of the DRAM arbiter.
// The master modport is the arbiter; the slave modport is the cache, FIFO and memory around it.
interface mem_arbiter_if;
  logic         is_req_f_prog;
  logic         is_req_f_data;
  logic [17:0]  req_addr_f_prog;
  logic [17:0]  req_addr_f_data;
  logic         fifo_empty;
  logic [31:0]  write_back_addr;
  logic [31:0]  write_back_data;
  logic         fifo_rd_en;
  logic [511:0] read_prog_data;
  logic [511:0] read_data_data;
  logic [7:0]   read_prog_addr;
  logic [7:0]   read_data_addr;
  logic         prog_fill_valid;
  logic         data_fill_valid;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ack;
  logic [31:0]  mem_rdata;

  // mem port handshake: an access is offered while mem_req=1 with mem_addr/mem_we/mem_wdata
  // held stable; it completes on the rising edge where mem_ack=1 (mem_rdata valid then).
  modport master (
    input  is_req_f_prog, is_req_f_data, req_addr_f_prog, req_addr_f_data,
    input  fifo_empty, write_back_addr, write_back_data,
    output fifo_rd_en,
    output read_prog_data, read_data_data, read_prog_addr, read_data_addr,
    output prog_fill_valid, data_fill_valid,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output is_req_f_prog, is_req_f_data, req_addr_f_prog, req_addr_f_data,
    output fifo_empty, write_back_addr, write_back_data,
    input  fifo_rd_en,
    input  read_prog_data, read_data_data, read_prog_addr, read_data_addr,
    input  prog_fill_valid, data_fill_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port DRAM arbiter: drains the write-back FIFO first, then refills 512-bit lines
// for the data or program cache, one 32-bit word access outstanding at a time.
module mem_arbiter (
  input  logic                dram_clk,
  input  logic                reset,
  mem_arbiter_if.master       bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, FILL = 2'd2, DONE = 2'd3} state_t;

  state_t        state, state_nxt;
  logic [31:0]   wb_addr, wb_data;
  logic [17:0]   line_addr;
  logic          src_data;
  logic [3:0]    beat;
  logic [511:0]  line_buf;
  logic          grant_wb, grant_data, grant_prog;
  logic          src_req;

  // Write-back always wins so a refill can never bypass an older store.
  always_comb begin
    grant_wb   = (state == IDLE) && !bus.fifo_empty;
    grant_data = (state == IDLE) && bus.fifo_empty && bus.is_req_f_data;
    grant_prog = (state == IDLE) && bus.fifo_empty && !bus.is_req_f_data && bus.is_req_f_prog;
    src_req    = src_data ? bus.is_req_f_data : bus.is_req_f_prog;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_wb)                      state_nxt = WB;
        else if (grant_data || grant_prog) state_nxt = FILL;
      end
      WB:   if (bus.mem_ack)                    state_nxt = IDLE;
      FILL: if (bus.mem_ack && beat == 4'd15)   state_nxt = DONE;
      DONE: if (!src_req)                       state_nxt = IDLE;
      default:                                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge dram_clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wb_addr   <= '0;
      wb_data   <= '0;
      line_addr <= '0;
      src_data  <= 1'b0;
      beat      <= '0;
      line_buf  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_wb) begin
        wb_addr <= bus.write_back_addr;
        wb_data <= bus.write_back_data;
      end
      if (grant_data || grant_prog) begin
        line_addr <= grant_data ? bus.req_addr_f_data : bus.req_addr_f_prog;
        src_data  <= grant_data;
        beat      <= '0;
      end
      if (state == FILL && bus.mem_ack) begin
        line_buf[{beat, 5'd0} +: 32] <= bus.mem_rdata;
        beat                         <= beat + 4'd1;
      end
    end
  end

  // The pop is gated by reset so a held reset cannot leak a pop of the FIFO head.
  always_comb begin
    bus.fifo_rd_en      = grant_wb && reset;
    bus.mem_req         = (state == WB) || (state == FILL);
    bus.mem_we          = (state == WB);
    bus.mem_addr        = '0;
    bus.mem_wdata       = '0;
    if (state == WB) begin
      bus.mem_addr  = wb_addr;
      bus.mem_wdata = wb_data;
    end else if (state == FILL) begin
      bus.mem_addr  = {8'd0, line_addr, beat, 2'b00};
    end
    bus.data_fill_valid = (state == DONE) && src_data;
    bus.prog_fill_valid = (state == DONE) && !src_data;
    bus.read_data_addr  = line_addr[7:0];
    bus.read_prog_addr  = line_addr[7:0];
    bus.read_data_data  = line_buf;
    bus.read_prog_data  = line_buf;
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: FIFO and memory models, scoreboard of expected
// memory accesses and line fills, directed scenarios for write-back, refill, priority and reset.
module tb_mem_arbiter;

  logic       dram_clk;
  logic       reset;
  logic [1:0] state_dbg;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .dram_clk  (dram_clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial dram_clk = 1'b0;
  always #5 dram_clk = ~dram_clk;

  // ---------------- bookkeeping ----------------
  int tests_run = 0;
  int fail_cnt  = 0;
  int acc_cnt   = 0;
  int pop_cnt   = 0;
  int fill_cnt  = 0;
  int ack_lo    = 0;
  int ack_hi    = 0;
  int rdata_mode = 0;

  logic [64:0]  exp_q[$];       // {we, addr, wdata (0 for reads)}
  logic [520:0] exp_fill_q[$];  // {src_data, index, line}
  logic [63:0]  fifo_q[$];      // {addr, data}

  task automatic chk(input string tag, input logic [520:0] obs, input logic [520:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdata_fn(input logic [31:0] a);
    if (rdata_mode == 0) return {28'd0, a[5:2]};
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [511:0] exp_line(input logic [17:0] l);
    logic [511:0] v;
    logic [3:0]   kk;
    v = '0;
    for (int k = 0; k < 16; k++) begin
      kk = k[3:0];
      v[32*k +: 32] = rdata_fn({8'd0, l, kk, 2'b00});
    end
    return v;
  endfunction

  task automatic update_fifo_head();
    bus.fifo_empty = (fifo_q.size() == 0);
    if (fifo_q.size() != 0) {bus.write_back_addr, bus.write_back_data} = fifo_q[0];
    else {bus.write_back_addr, bus.write_back_data} = 64'd0;
  endtask

  task automatic push_wb(input logic [31:0] a, input logic [31:0] d);
    fifo_q.push_back({a, d});
    exp_q.push_back({1'b1, a, d});
    update_fifo_head();
  endtask

  task automatic push_fill(input logic src, input logic [17:0] l);
    logic [3:0] kk;
    for (int k = 0; k < 16; k++) begin
      kk = k[3:0];
      exp_q.push_back({1'b0, 8'd0, l, kk, 2'b00, 32'd0});
    end
    exp_fill_q.push_back({src, l[7:0], exp_line(l)});
  endtask

  task automatic step();
    @(posedge dram_clk);
    #2;
  endtask

  task automatic wait_q_empty(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge dram_clk);
      n++;
    end
    chk(tag, exp_q.size() == 0, 1'b1);
  endtask

  task automatic wait_valid(input string tag, input logic sel_data, input logic want, input int budget);
    int   n = 0;
    logic v;
    @(negedge dram_clk);
    v = sel_data ? bus.data_fill_valid : bus.prog_fill_valid;
    while (v !== want && n < budget) begin
      @(negedge dram_clk);
      v = sel_data ? bus.data_fill_valid : bus.prog_fill_valid;
      n++;
    end
    chk(tag, v, want);
  endtask

  task automatic chk_outputs_zero(input string p);
    chk({p, "_mem_req"},   bus.mem_req, 1'b0);
    chk({p, "_mem_we"},    bus.mem_we, 1'b0);
    chk({p, "_mem_addr"},  bus.mem_addr, 32'd0);
    chk({p, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({p, "_rd_en"},     bus.fifo_rd_en, 1'b0);
    chk({p, "_valids"},    {bus.prog_fill_valid, bus.data_fill_valid}, 2'b00);
    chk({p, "_idx"},       {bus.read_prog_addr, bus.read_data_addr}, 16'd0);
    chk({p, "_line"},      {bus.read_prog_data | bus.read_data_data}, 512'd0);
    chk({p, "_state"},     state_dbg, 2'd0);
  endtask

  // ---------------- FIFO model (show-ahead) ----------------
  initial begin
    forever begin
      @(negedge dram_clk);
      if (bus.fifo_rd_en === 1'b1) begin
        chk("pop_nonempty", bus.fifo_empty, 1'b0);
        pop_cnt++;
        @(posedge dram_clk);
        #1;
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        update_fifo_head();
      end
    end
  end

  // ---------------- memory responder + access scoreboard ----------------
  initial begin
    int          wait_cnt;
    int          cur_delay;
    logic        fresh;
    logic        prev_req;
    logic [31:0] prev_addr;
    logic [64:0] obs;
    wait_cnt = 0; cur_delay = 0; fresh = 1'b1; prev_req = 1'b0; prev_addr = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge dram_clk);
      if (bus.mem_req === 1'b1) begin
        if (prev_req && !bus.mem_ack) chk("addr_stable", bus.mem_addr, prev_addr);
        if (fresh) begin
          cur_delay = $urandom_range(ack_hi, ack_lo);
          fresh = 1'b0;
        end
        if (wait_cnt >= cur_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rdata_fn(bus.mem_addr);
          acc_cnt++;
          obs = {bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 32'd0};
          chk("acc_pending", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) chk("mem_acc", obs, exp_q.pop_front());
          wait_cnt = 0;
          fresh = 1'b1;
        end else begin
          bus.mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        wait_cnt = 0;
        fresh = 1'b1;
      end
      prev_req  = bus.mem_req;
      prev_addr = bus.mem_addr;
    end
  end

  // ---------------- fill monitor ----------------
  initial begin
    logic         prev_dv, prev_pv;
    logic [520:0] obs;
    prev_dv = 1'b0; prev_pv = 1'b0;
    forever begin
      @(negedge dram_clk);
      if ((bus.data_fill_valid && !prev_dv) || (bus.prog_fill_valid && !prev_pv)) begin
        fill_cnt++;
        chk("fill_excl", bus.data_fill_valid & bus.prog_fill_valid, 1'b0);
        obs = bus.data_fill_valid ? {1'b1, bus.read_data_addr, bus.read_data_data}
                                  : {1'b0, bus.read_prog_addr, bus.read_prog_data};
        chk("fill_pending", exp_fill_q.size() != 0, 1'b1);
        if (exp_fill_q.size() != 0) chk("fill_line", obs, exp_fill_q.pop_front());
      end
      prev_dv = bus.data_fill_valid;
      prev_pv = bus.prog_fill_valid;
    end
  end

  // ---------------- global watchdog ----------------
  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int base;
    reset = 1'b0;
    bus.is_req_f_prog = 1'b0;
    bus.is_req_f_data = 1'b0;
    bus.req_addr_f_prog = '0;
    bus.req_addr_f_data = '0;
    update_fifo_head();

    // Reset state, with a FIFO entry already present while reset is held
    #1;
    chk_outputs_zero("rst");
    ack_lo = 3; ack_hi = 3;
    push_wb(32'h0000_0100, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge dram_clk);
      chk("rst_hold_rd_en", bus.fifo_rd_en, 1'b0);
      chk("rst_hold_req", bus.mem_req, 1'b0);
    end

    // Single write-back, ack delayed 3 cycles; grant on first edge after release
    pop_cnt = 0;
    step();
    reset = 1'b1;
    @(negedge dram_clk);
    chk("first_grant_rd_en", bus.fifo_rd_en, 1'b1);
    wait_q_empty("wb_done", 60);
    repeat (3) step();
    chk("wb_pop_count", pop_cnt, 1);
    chk("wb_req_low", bus.mem_req, 1'b0);
    chk("wb_idle", state_dbg, 2'd0);

    // Data refill of line 0x00A5, ack tied high, rdata = beat index
    ack_lo = 0; ack_hi = 0; rdata_mode = 0;
    push_fill(1'b1, 18'h000A5);
    bus.req_addr_f_data = 18'h000A5;
    bus.is_req_f_data = 1'b1;
    n = 0;
    do begin
      @(posedge dram_clk);
      n++;
      @(negedge dram_clk);
    end while (!bus.data_fill_valid && n < 40);
    chk("fill_latency", n, 17);
    chk("read_data_addr", bus.read_data_addr, 8'hA5);
    chk("word15", bus.read_data_data[511:480], 32'd15);
    chk("word0", bus.read_data_data[31:0], 32'd0);
    step();
    bus.is_req_f_data = 1'b0;
    wait_valid("data_valid_drop", 1'b1, 1'b0, 5);
    chk("a5_q_empty", exp_q.size() == 0, 1'b1);

    // Two write-backs plus both refill requests at once
    ack_lo = 0; ack_hi = 2; rdata_mode = 1;
    step();
    push_wb(32'h0000_0200, 32'h1111_1111);
    push_wb(32'h0000_0204, 32'h2222_2222);
    push_fill(1'b1, 18'h12345);
    push_fill(1'b0, 18'h00F0F);
    bus.req_addr_f_data = 18'h12345;
    bus.req_addr_f_prog = 18'h00F0F;
    bus.is_req_f_data = 1'b1;
    bus.is_req_f_prog = 1'b1;
    wait_valid("mix_data_valid", 1'b1, 1'b1, 300);
    chk("mix_prog_wait", bus.prog_fill_valid, 1'b0);
    bus.is_req_f_data = 1'b0;
    wait_valid("mix_prog_valid", 1'b0, 1'b1, 300);
    bus.is_req_f_prog = 1'b0;
    wait_valid("mix_prog_drop", 1'b0, 1'b0, 5);
    wait_q_empty("mix_q_empty", 10);
    chk("mix_fill_q_empty", exp_fill_q.size() == 0, 1'b1);
    chk("mix_fifo_empty", bus.fifo_empty, 1'b1);

    // Prog request held 5 cycles after valid; no second fill
    ack_lo = 0; ack_hi = 1;
    step();
    push_fill(1'b0, 18'h30001);
    bus.req_addr_f_prog = 18'h30001;
    bus.is_req_f_prog = 1'b1;
    wait_valid("hold_valid_rise", 1'b0, 1'b1, 300);
    for (int i = 0; i < 5; i++) begin
      @(posedge dram_clk);
      @(negedge dram_clk);
      chk("hold_valid", bus.prog_fill_valid, 1'b1);
    end
    bus.is_req_f_prog = 1'b0;
    @(posedge dram_clk);
    @(negedge dram_clk);
    chk("hold_valid_drop", bus.prog_fill_valid, 1'b0);
    repeat (20) step();
    chk("hold_no_refill", bus.mem_req, 1'b0);
    chk("hold_q_empty", exp_q.size() == 0, 1'b1);

    // Reset asserted at beat 7 of a refill
    ack_lo = 0; ack_hi = 1; rdata_mode = 0;
    step();
    push_fill(1'b1, 18'h00077);
    bus.req_addr_f_data = 18'h00077;
    bus.is_req_f_data = 1'b1;
    base = acc_cnt;
    n = 0;
    while (acc_cnt < base + 7 && n < 100) begin
      @(posedge dram_clk);
      n++;
    end
    chk("beat7_reached", acc_cnt >= base + 7, 1'b1);
    chk("beat7_in_fill", state_dbg, 2'd2);
    #3;
    reset = 1'b0;
    bus.is_req_f_data = 1'b0;
    #1;
    chk_outputs_zero("midfill_rst");
    exp_q.delete();
    exp_fill_q.delete();
    repeat (3) step();
    reset = 1'b1;
    pop_cnt = 0;
    repeat (10) step();
    chk("post_rst_idle", state_dbg, 2'd0);
    chk("post_rst_req", bus.mem_req, 1'b0);
    chk("post_rst_valids", {bus.prog_fill_valid, bus.data_fill_valid}, 2'b00);
    chk("post_rst_pops", pop_cnt, 0);
    chk("total_fills", fill_cnt, 4);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
